// File: rtl/wasca_onchip_memory_dp_if.sv
// Avalon-MM slave bundle for one port of the dual-port buffer RAM.
// The master drives the request side; the slave returns read data and back-pressure.
interface wasca_onchip_memory_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/wasca_onchip_memory_dp.sv
// True-dual-port shared buffer RAM with two Avalon-MM slaves, zero-fill after reset
// and pipelined reads.  state | meaning:  ST_CLEAR | zero-filling, both ports held off;
// ST_READY | normal dual-port access until the next reset.
module wasca_onchip_memory_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int DEPTH          = 2560,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clken,
    input  logic                     reset_req,
    wasca_onchip_memory_dp_if.slave  s1,
    wasca_onchip_memory_dp_if.slave  s2,
    output logic                     init_busy
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    logic                    en;
    logic                    waitreq;
    logic [ADDR_WIDTH-1:0]   addr  [2];
    logic [NB-1:0]           be    [2];
    logic [DATA_WIDTH-1:0]   wdata [2];
    logic [1:0]              cs, rd, wr;
    logic [1:0]              acc_wr, acc_rd, in_range;

    logic [1:0]              v1, v2;
    logic [DATA_WIDTH-1:0]   d1 [2];
    logic [DATA_WIDTH-1:0]   d2 [2];

    assign en = clken & ~reset_req;
    // Reset forces back-pressure combinationally so nothing is accepted in the reset cycle.
    assign waitreq = reset | ~en | (state != ST_READY);

    assign addr[0]  = s1.address;
    assign addr[1]  = s2.address;
    assign be[0]    = s1.byteenable;
    assign be[1]    = s2.byteenable;
    assign wdata[0] = s1.writedata;
    assign wdata[1] = s2.writedata;
    assign cs       = {s2.chipselect, s1.chipselect};
    assign rd       = {s2.read, s1.read};
    assign wr       = {s2.write, s1.write};

    always_comb begin
        acc_wr   = '0;
        acc_rd   = '0;
        in_range = '0;
        for (int p = 0; p < 2; p++) begin
            acc_wr[p]   = cs[p] & wr[p] & ~waitreq;
            acc_rd[p]   = cs[p] & rd[p] & ~wr[p] & ~waitreq;
            in_range[p] = ({1'b0, addr[p]} < DEPTH_L);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr  <= '0;
            init_busy <= (CLEAR_ON_RESET != 0);
        end else if (en) begin
            case (state)
                ST_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state     <= ST_READY;
                        init_busy <= 1'b0;
                    end else begin
                        clr_addr  <= clr_addr + 1'b1;
                    end
                end
                default: state <= ST_READY;
            endcase
        end
    end

    // s2 lanes are written first so an s1 lane hitting the same word overrides it.
    always_ff @(posedge clk) begin
        if (!reset && en && state == ST_CLEAR) begin
            mem[clr_addr] <= '0;
        end
        for (int p = 1; p >= 0; p--) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_wr[p] && in_range[p] && be[p][b]) begin
                    mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
                end
            end
        end
    end

    // Registered read samples the array before this edge's writes land: read-during-write is old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= '0;
            v2 <= '0;
            for (int p = 0; p < 2; p++) begin
                d1[p] <= '0;
                d2[p] <= '0;
            end
        end else if (en) begin
            v1 <= acc_rd;
            v2 <= v1;
            for (int p = 0; p < 2; p++) begin
                if (acc_rd[p]) begin
                    d1[p] <= in_range[p] ? mem[addr[p]] : '0;
                end
                d2[p] <= d1[p];
            end
        end
    end

    assign s1.waitrequest   = waitreq;
    assign s2.waitrequest   = waitreq;
    assign s1.readdatavalid = (READ_LATENCY == 2) ? v2[0] : v1[0];
    assign s2.readdatavalid = (READ_LATENCY == 2) ? v2[1] : v1[1];
    assign s1.readdata      = (READ_LATENCY == 2) ? d2[0] : d1[0];
    assign s2.readdata      = (READ_LATENCY == 2) ? d2[1] : d1[1];
endmodule

// File: tb/tb_wasca_onchip_memory_dp.sv
// Directed bench for the dual-port buffer RAM; two instances share one stimulus,
// one with single-cycle and one with two-cycle read latency.
module tb_wasca_onchip_memory_dp;
    logic clk;
    logic reset;
    logic clken;
    logic reset_req;
    logic busy_a, busy_b;

    logic        cs_v   [2];
    logic        rd_v   [2];
    logic        wr_v   [2];
    logic [11:0] addr_v [2];
    logic [3:0]  be_v   [2];
    logic [31:0] wd_v   [2];

    logic [31:0] rd_a  [2];
    logic [31:0] rd_b  [2];
    logic        rdv_a [2];
    logic        rdv_b [2];
    logic        wr_a  [2];
    logic        wr_b  [2];

    int n_checks = 0;
    int n_fail   = 0;

    wasca_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) ia1 ();
    wasca_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) ia2 ();
    wasca_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) ib1 ();
    wasca_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) ib2 ();

    wasca_onchip_memory_dp #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1(ia1), .s2(ia2), .init_busy(busy_a)
    );

    wasca_onchip_memory_dp #(.READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1(ib1), .s2(ib2), .init_busy(busy_b)
    );

    assign ia1.address = addr_v[0];  assign ib1.address = addr_v[0];
    assign ia2.address = addr_v[1];  assign ib2.address = addr_v[1];
    assign ia1.chipselect = cs_v[0]; assign ib1.chipselect = cs_v[0];
    assign ia2.chipselect = cs_v[1]; assign ib2.chipselect = cs_v[1];
    assign ia1.read = rd_v[0];       assign ib1.read = rd_v[0];
    assign ia2.read = rd_v[1];       assign ib2.read = rd_v[1];
    assign ia1.write = wr_v[0];      assign ib1.write = wr_v[0];
    assign ia2.write = wr_v[1];      assign ib2.write = wr_v[1];
    assign ia1.byteenable = be_v[0]; assign ib1.byteenable = be_v[0];
    assign ia2.byteenable = be_v[1]; assign ib2.byteenable = be_v[1];
    assign ia1.writedata = wd_v[0];  assign ib1.writedata = wd_v[0];
    assign ia2.writedata = wd_v[1];  assign ib2.writedata = wd_v[1];

    assign rd_a[0] = ia1.readdata;       assign rd_a[1] = ia2.readdata;
    assign rd_b[0] = ib1.readdata;       assign rd_b[1] = ib2.readdata;
    assign rdv_a[0] = ia1.readdatavalid; assign rdv_a[1] = ia2.readdatavalid;
    assign rdv_b[0] = ib1.readdatavalid; assign rdv_b[1] = ib2.readdatavalid;
    assign wr_a[0] = ia1.waitrequest;    assign wr_a[1] = ia2.waitrequest;
    assign wr_b[0] = ib1.waitrequest;    assign wr_b[1] = ib2.waitrequest;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clr_req();
        for (int p = 0; p < 2; p++) begin
            cs_v[p] = 1'b0; rd_v[p] = 1'b0; wr_v[p] = 1'b0;
            addr_v[p] = '0; be_v[p] = '0; wd_v[p] = '0;
        end
    endtask

    task automatic set_req(input int p, input bit r, input bit w, input logic [11:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        cs_v[p] = 1'b1; rd_v[p] = r; wr_v[p] = w;
        addr_v[p] = a; wd_v[p] = d; be_v[p] = be;
    endtask

    task automatic do_write(input int p, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        set_req(p, 1'b0, 1'b1, a, d, be);
        @(negedge clk);
        clr_req();
    endtask

    // Request must already be presented; returns first valid data and its cycle offset per DUT.
    task automatic rd_collect(input int p, output logic [31:0] da, output logic [31:0] db,
                              output int la, output int lb);
        la = 0; lb = 0; da = '0; db = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) clr_req();
            if (rdv_a[p] && la == 0) begin la = k; da = rd_a[p]; end
            if (rdv_b[p] && lb == 0) begin lb = k; db = rd_b[p]; end
        end
    endtask

    task automatic check_rd(input string tag, input int p, input logic [31:0] exp);
        logic [31:0] da, db;
        int la, lb;
        rd_collect(p, da, db, la, lb);
        check({tag, "_data_l1"}, da, exp);
        check({tag, "_lat_l1"}, 32'(la), 32'd1);
        check({tag, "_data_l2"}, db, exp);
        check({tag, "_lat_l2"}, 32'(lb), 32'd2);
    endtask

    task automatic do_read(input string tag, input int p, input logic [11:0] a,
                           input logic [31:0] exp);
        set_req(p, 1'b1, 1'b0, a, '0, '0);
        check_rd(tag, p, exp);
    endtask

    task automatic do_reset(input bit chk);
        reset = 1'b1;
        @(negedge clk);
        if (chk) begin
            for (int p = 0; p < 2; p++) begin
                check("rst_valid", 32'(rdv_a[p]), 32'd0);
                check("rst_rdata", rd_a[p], 32'd0);
                check("rst_wait",  32'(wr_a[p]), 32'd1);
            end
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic count_busy(output int nb, output int nw, output int nv, output int nd);
        nb = 0; nw = 0; nv = 0; nd = 0;
        while (busy_a && nb < 6000) begin
            nb++;
            if (wr_a[0] && wr_a[1] && wr_b[0] && wr_b[1]) nw++;
            if (rdv_a[0] || rdv_a[1] || rdv_b[0] || rdv_b[1]) nv++;
            if (busy_b !== busy_a) nd++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nb, nw, nv, nd, nv_pre;
        int acc, na, nbv, last_a, last_b;
        bit en_prev;
        logic [31:0] got_a [4];
        logic [31:0] got_b [4];
        logic [31:0] da, db;
        int la, lb;

        clr_req();
        clken = 1'b1;
        reset_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // zero-fill after a one-cycle reset
        do_reset(1'b1);
        count_busy(nb, nw, nv, nd);
        check("t1_busy_cycles", 32'(nb), 32'd2560);
        check("t1_wait_cycles", 32'(nw), 32'd2560);
        check("t1_no_valid", 32'(nv), 32'd0);
        check("t1_busy_b_match", 32'(nd), 32'd0);
        check("t1_wait_after", 32'(wr_a[0]), 32'd0);
        check("t1_busy_b_after", 32'(busy_b), 32'd0);
        do_read("t1_rd0", 0, 12'd0, 32'h0000_0000);
        do_read("t1_rd2559", 0, 12'd2559, 32'h0000_0000);

        // reset_req behaves as a stall
        reset_req = 1'b1;
        #1;
        check("rreq_wait_s1", 32'(wr_a[0]), 32'd1);
        check("rreq_wait_s2", 32'(wr_b[1]), 32'd1);
        reset_req = 1'b0;
        #1;
        check("rreq_release", 32'(wr_a[1]), 32'd0);
        @(negedge clk);

        // read latency on both instances
        do_write(0, 12'd5, 32'hA5A5_1234, 4'hF);
        do_read("t2_rd5", 0, 12'd5, 32'hA5A5_1234);

        // byte lanes and dual-write collision
        do_write(0, 12'd7, 32'h0000_0000, 4'hF);
        set_req(0, 1'b0, 1'b1, 12'd7, 32'h1111_1111, 4'b0011);
        set_req(1, 1'b0, 1'b1, 12'd7, 32'h2222_2222, 4'b0110);
        @(negedge clk);
        clr_req();
        do_read("t3_rd7_s1", 0, 12'd7, 32'h0022_1111);
        do_read("t3_rd7_s2", 1, 12'd7, 32'h0022_1111);

        // read-during-write across ports returns old data
        do_write(1, 12'd9, 32'hDEAD_BEEF, 4'hF);
        set_req(0, 1'b0, 1'b1, 12'd9, 32'h0000_0000, 4'hF);
        set_req(1, 1'b1, 1'b0, 12'd9, '0, '0);
        check_rd("t4_rdw", 1, 32'hDEAD_BEEF);
        do_read("t4_after", 1, 12'd9, 32'h0000_0000);

        // read+write on one port counts as a write only
        set_req(0, 1'b1, 1'b1, 12'd11, 32'h5A5A_0F0F, 4'hF);
        rd_collect(0, da, db, la, lb);
        check("rw_no_valid", 32'(la + lb), 32'd0);
        do_read("rw_written", 0, 12'd11, 32'h5A5A_0F0F);

        // out-of-range decode
        do_read("t5_oor_rd", 1, 12'd3000, 32'h0000_0000);
        do_write(1, 12'd3000, 32'hFFFF_FFFF, 4'hF);
        do_read("t5_oor_rd2", 1, 12'd3000, 32'h0000_0000);
        do_read("t5_keep5", 0, 12'd5, 32'hA5A5_1234);
        do_read("t5_keep2559", 1, 12'd2559, 32'h0000_0000);

        // back-to-back reads with a one-cycle clock-enable stall
        for (int i = 0; i < 4; i++) do_write(0, 12'(20 + i), 32'h0000_0100 + 32'(i), 4'hF);
        acc = 0; na = 0; nbv = 0; last_a = 0; last_b = 0;
        for (int c = 0; c < 9; c++) begin
            if (acc < 4) set_req(0, 1'b1, 1'b0, 12'(20 + acc), '0, '0);
            else clr_req();
            clken = (c != 1);
            en_prev = clken;
            #1;
            if (c == 1) check("t5_stall_wait", 32'(wr_a[0]), 32'd1);
            @(negedge clk);
            if (en_prev && acc < 4) acc++;
            if (en_prev) begin
                if (rdv_a[0]) begin
                    if (na < 4) got_a[na] = rd_a[0];
                    na++; last_a = c + 1;
                end
                if (rdv_b[0]) begin
                    if (nbv < 4) got_b[nbv] = rd_b[0];
                    nbv++; last_b = c + 1;
                end
            end
        end
        clr_req();
        clken = 1'b1;
        check("t5_count_l1", 32'(na), 32'd4);
        check("t5_count_l2", 32'(nbv), 32'd4);
        check("t5_last_l1", 32'(last_a), 32'd5);
        check("t5_last_l2", 32'(last_b), 32'd6);
        for (int i = 0; i < 4; i++) begin
            check("t5_order_l1", (na > i) ? got_a[i] : 32'hXXXX_XXXX, 32'h0000_0100 + 32'(i));
            check("t5_order_l2", (nbv > i) ? got_b[i] : 32'hXXXX_XXXX, 32'h0000_0100 + 32'(i));
        end

        // reset in the middle of the zero-fill restarts it
        do_reset(1'b0);
        nv_pre = 0;
        for (int c = 0; c < 1000; c++) begin
            if (rdv_a[0] || rdv_a[1] || rdv_b[0] || rdv_b[1]) nv_pre++;
            if (!busy_a) nv_pre++;
            @(negedge clk);
        end
        check("t6_first_clear", 32'(nv_pre), 32'd0);
        do_reset(1'b0);
        count_busy(nb, nw, nv, nd);
        check("t6_busy_cycles", 32'(nb), 32'd2560);
        check("t6_wait_cycles", 32'(nw), 32'd2560);
        check("t6_no_valid", 32'(nv), 32'd0);
        check("t6_busy_b_match", 32'(nd), 32'd0);
        do_read("t6_rd5", 0, 12'd5, 32'h0000_0000);
        do_read("t6_rd9", 1, 12'd9, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
